// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the pulse stretcher.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} ps_state_t;

  localparam int MIN_GAP_CYCLES = 1;

endpackage

// File: rtl/pulse_stretch_down_counter.sv
// Loadable down-counter that stops at zero; one instance times both the
// high level and the forced low gap of the pulse stretcher.
module pulse_down_counter
  import pulse_stretch_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle triggers into high levels of programmable width, each
// followed by a forced low gap. Optional trigger queue: PULSE_STRETCH_PENDING_EN.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int WIDTH_W    = 8,
  parameter int GAP_CYCLES = 2,
  parameter int PEND_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_trig_in,
  input  logic [WIDTH_W-1:0] i_width_cfg,
  output logic               o_level_out,
  output logic               o_busy,
  output logic [PEND_W-1:0]  o_pending_cnt,
  output logic               o_drop_pulse
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = (WIDTH_W > GAP_W) ? WIDTH_W : GAP_W;

  if (GAP_CYCLES < MIN_GAP_CYCLES) begin : g_gap_check
    $error("pulse_stretch: GAP_CYCLES must be >= %0d", MIN_GAP_CYCLES);
  end

  ps_state_t          r_state;
  ps_state_t          w_next;
  logic               r_level;
  logic               r_busy;
  logic               r_drop;
  logic               w_level_d;
  logic               w_busy_d;
  logic               w_drop;
  logic               w_pend_nz;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_zero;
  logic [WIDTH_W-1:0] w_width_m1;
  logic [CNT_W-1:0]   w_high_val;
  logic [CNT_W-1:0]   w_gap_val;

  // A width of 0 behaves as 1; the counter holds cycles remaining minus one.
  assign w_width_m1 = (i_width_cfg == '0) ? '0 : (i_width_cfg - WIDTH_W'(1));
  assign w_high_val = CNT_W'(w_width_m1);
  assign w_gap_val  = CNT_W'(GAP_CYCLES - 1);

  pulse_down_counter #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

`ifdef PULSE_STRETCH_PENDING_EN
  logic [PEND_W-1:0] r_pend;
  logic              w_enq;
  logic              w_deq;
  logic              w_full;

  // A queued trigger left over in IDLE (queued on the last gap cycle) is served
  // at once; a trigger arriving alongside it is queued behind it.
  assign w_pend_nz = (r_pend != '0);
  assign w_full    = &r_pend;
  assign w_enq     = i_trig_in && ((r_state != IDLE) || w_pend_nz);
  assign w_deq     = w_pend_nz && ((r_state == IDLE) || ((r_state == GAP) && w_zero));
  assign w_drop    = w_enq && !w_deq && w_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (w_enq && !w_deq && !w_full) begin
      r_pend <= r_pend + PEND_W'(1);
    end else if (w_deq && !w_enq) begin
      r_pend <= r_pend - PEND_W'(1);
    end
  end

  assign o_pending_cnt = r_pend;
`else
  assign w_pend_nz     = 1'b0;
  assign w_drop        = i_trig_in && (r_state != IDLE);
  assign o_pending_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_level <= w_level_d;
      r_busy  <= w_busy_d;
      r_drop  <= w_drop;
    end
  end

  // Every entry into HIGH reloads the timer, which is how width_cfg gets latched.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: begin
        if (i_trig_in || w_pend_nz) begin
          w_next     = HIGH;
          w_load     = 1'b1;
          w_load_val = w_high_val;
        end
      end
      HIGH: begin
        if (w_zero) begin
          w_next     = GAP;
          w_load     = 1'b1;
          w_load_val = w_gap_val;
        end
      end
      GAP: begin
        if (w_zero) begin
          if (w_pend_nz) begin
            w_next     = HIGH;
            w_load     = 1'b1;
            w_load_val = w_high_val;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_level_d = (w_next == HIGH);
    w_busy_d  = (w_next != IDLE);
  end

  assign o_level_out  = r_level;
  assign o_busy       = r_busy;
  assign o_drop_pulse = r_drop;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch; scenario set follows PULSE_STRETCH_PENDING_EN.
module tb_pulse_stretch;

  logic       clk;
  logic       rst_n;
  logic       trig;
  logic [7:0] widthCfg;
  logic       level;
  logic       busy;
  logic [1:0] pend;
  logic       drop;

  int checks   = 0;
  int failures = 0;

  logic det1 = 1'b0;
  logic det2 = 1'b0;
  int   detCnt = 0;

  pulse_stretch #(.WIDTH_W(8), .GAP_CYCLES(2), .PEND_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_trig_in     (trig),
    .i_width_cfg   (widthCfg),
    .o_level_out   (level),
    .o_busy        (busy),
    .o_pending_cnt (pend),
    .o_drop_pulse  (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream two-flop rising-edge detector used by the loopback scenario.
  always @(posedge clk) begin
    det1 <= level;
    det2 <= det1;
    if (det1 && !det2) detCnt <= detCnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trig = 1'b0; widthCfg = 8'd1;
    repeat (3) step();
    checks++; if (level !== 1'b0) begin failures++; $display("[TB] FAIL reset_level got=%b want=0", level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (pend !== 2'd0) begin failures++; $display("[TB] FAIL reset_pending got=%0d want=0", pend); end
    checks++; if (drop !== 1'b0) begin failures++; $display("[TB] FAIL reset_drop got=%b want=0", drop); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_level();
    widthCfg = 8'd3; trig = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      trig = 1'b0;
      if (k == 1) widthCfg = 8'd9;
      checks++; if (level !== (k <= 3)) begin failures++; $display("[TB] FAIL single_level k=%0d got=%b want=%b", k, level, (k <= 3)); end
      checks++; if (busy !== (k <= 5)) begin failures++; $display("[TB] FAIL single_busy k=%0d got=%b want=%b", k, busy, (k <= 5)); end
      checks++; if (drop !== 1'b0) begin failures++; $display("[TB] FAIL single_drop k=%0d got=%b want=0", k, drop); end
    end
  endtask

  task automatic test_zero_width();
    widthCfg = 8'd0; trig = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      trig = 1'b0;
      checks++; if (level !== (k == 1)) begin failures++; $display("[TB] FAIL zero_level k=%0d got=%b want=%b", k, level, (k == 1)); end
      checks++; if (busy !== (k <= 3)) begin failures++; $display("[TB] FAIL zero_busy k=%0d got=%b want=%b", k, busy, (k <= 3)); end
    end
  endtask

`ifdef PULSE_STRETCH_PENDING_EN
  task automatic test_back_to_back();
    widthCfg = 8'd4; trig = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      trig = (k == 2);
      checks++;
      if (level !== ((k >= 1 && k <= 4) || (k >= 7 && k <= 10))) begin
        failures++; $display("[TB] FAIL b2b_level k=%0d got=%b", k, level);
      end
      checks++;
      if (pend !== ((k >= 3 && k <= 6) ? 2'd1 : 2'd0)) begin
        failures++; $display("[TB] FAIL b2b_pending k=%0d got=%0d want=%0d", k, pend, (k >= 3 && k <= 6));
      end
    end
  endtask

  task automatic test_saturation();
    int drops = 0;
    int rises = 0;
    logic prev = 1'b0;
    widthCfg = 8'd20; trig = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      trig = (k == 2 || k == 4 || k == 6 || k == 8 || k == 10);
      if (drop) drops++;
      if (level && !prev) rises++;
      prev = level;
      if (k == 8) begin
        checks++; if (pend !== 2'd3) begin failures++; $display("[TB] FAIL sat_pending got=%0d want=3", pend); end
      end
      if (k == 12) begin
        checks++; if (pend !== 2'd3) begin failures++; $display("[TB] FAIL sat_hold got=%0d want=3", pend); end
      end
    end
    checks++; if (drops != 2) begin failures++; $display("[TB] FAIL sat_drops got=%0d want=2", drops); end
    checks++; if (rises != 4) begin failures++; $display("[TB] FAIL sat_levels got=%0d want=4", rises); end
    checks++; if (busy !== 1'b0 || pend !== 2'd0) begin failures++; $display("[TB] FAIL sat_drained busy=%b pending=%0d want 0/0", busy, pend); end
  endtask
`else
  task automatic test_drop_no_queue();
    int rises = 0;
    logic prev = 1'b0;
    widthCfg = 8'd3; trig = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      trig = (k == 2);
      if (level && !prev) rises++;
      prev = level;
      checks++; if (drop !== (k == 3)) begin failures++; $display("[TB] FAIL nq_drop k=%0d got=%b want=%b", k, drop, (k == 3)); end
      checks++; if (level !== (k <= 3)) begin failures++; $display("[TB] FAIL nq_level k=%0d got=%b want=%b", k, level, (k <= 3)); end
      checks++; if (pend !== 2'd0) begin failures++; $display("[TB] FAIL nq_pending k=%0d got=%0d want=0", k, pend); end
    end
    checks++; if (rises != 1) begin failures++; $display("[TB] FAIL nq_levels got=%0d want=1", rises); end
  endtask
`endif

  task automatic test_mid_reset();
    widthCfg = 8'd5; trig = 1'b1;
    step();
    step();
    trig = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (level !== 1'b0) begin failures++; $display("[TB] FAIL mrst_level got=%b want=0", level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mrst_busy got=%b want=0", busy); end
    checks++; if (pend !== 2'd0) begin failures++; $display("[TB] FAIL mrst_pending got=%0d want=0", pend); end
    checks++; if (drop !== 1'b0) begin failures++; $display("[TB] FAIL mrst_drop got=%b want=0", drop); end
    repeat (3) step();
    checks++; if (level !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mrst_idle level=%b busy=%b want 0/0", level, busy); end
  endtask

  task automatic test_loopback();
    int issued = 0;
    int drops = 0;
    int startDet;
    bit drained = 0;
    startDet = detCnt;
    trig = 1'b0;
    while (issued < 200) begin
      step();
      if (drop) drops++;
      widthCfg = 8'($urandom_range(4));
      trig = ($urandom_range(3) == 0);
      if (trig) issued++;
    end
    for (int k = 0; k < 3000 && !drained; k++) begin
      step();
      trig = 1'b0;
      if (drop) drops++;
      if (!busy && pend == 2'd0) drained = 1;
    end
    checks++; if (!drained) begin failures++; $display("[TB] FAIL loop_drain got=busy want=idle"); end
    repeat (4) begin
      step();
      if (drop) drops++;
    end
    checks++;
    if (detCnt - startDet != issued - drops) begin
      failures++; $display("[TB] FAIL loop_edges got=%0d want=%0d", detCnt - startDet, issued - drops);
    end
  endtask

  initial begin
    test_reset();
    test_single_level();
    test_zero_width();
`ifdef PULSE_STRETCH_PENDING_EN
    test_back_to_back();
    test_saturation();
`else
    test_drop_no_queue();
`endif
    test_mid_reset();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
